// File: rtl/window_max_ugt_pkg.sv
// Shared definitions for the windowed-maximum stage.
//   state_t        : stage state (ACCUM collecting samples, HOLD result presented)
//   WIDTH_DEFAULT  : default sample width in bits
//   idx_w()        : index/counter width for a given window length
package window_max_ugt_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 4;

    // clog2 with a floor of one bit so a counter always exists.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_max_ugt_if.sv
// Sample/result stream bundle for window_max_ugt.
//   I, I_valid, I_ready       : sample input handshake
//   O_max, O_idx, O_valid,
//   O_ready                   : window result handshake
// slave  : the windowed-maximum stage
// master : the environment driving samples and taking results
interface window_max_ugt_if
    import window_max_ugt_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned IDX_W = 3
);
    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O_max;
    logic [IDX_W-1:0] O_idx;
    logic             O_valid;
    logic             O_ready;

    modport slave (
        input  I, I_valid, O_ready,
        output I_ready, O_max, O_idx, O_valid
    );

    modport master (
        output I, I_valid, O_ready,
        input  I_ready, O_max, O_idx, O_valid
    );
endinterface

// File: rtl/window_max_ugt_ugt.sv
// WIDTH-bit unsigned strict greater-than comparator.
//   in0, in1 : unsigned operands
//   out      : 1 when in0 > in1 (no sign extension)
module window_max_ugt_ugt
    import window_max_ugt_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out
);
    assign out = (in0 > in1);
endmodule

// File: rtl/window_max_ugt.sv
// Streaming windowed maximum: emits the maximum of every WINDOW accepted
// samples together with the index of its first occurrence.
//   CLK        : rising-edge clock
//   ASYNCRESET : asynchronous active-high reset
//   bus        : sample input (I/I_valid/I_ready) and registered result
//                output (O_max/O_idx/O_valid/O_ready)
module window_max_ugt
    import window_max_ugt_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEFAULT,
    parameter int unsigned WINDOW = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    window_max_ugt_if.slave  bus
);
    localparam int unsigned IDX_W = idx_w(WINDOW);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic i_ready;
    logic accept;
    logic gt;

    // In HOLD the next window's first sample may enter on the same edge the
    // result is taken, so readiness follows the downstream.
    assign i_ready = (state_q == ACCUM) || bus.O_ready;
    assign accept  = bus.I_valid && i_ready;

    window_max_ugt_ugt #(
        .WIDTH (WIDTH)
    ) u_ugt (
        .in0 (bus.I),
        .in1 (max_q),
        .out (gt)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_d   = max_q;
        idx_d   = idx_q;
        valid_d = valid_q;

        if (state_q == HOLD && bus.O_ready) begin
            state_d = ACCUM;
            valid_d = 1'b0;
        end

        if (accept) begin
            // count is 0 whenever HOLD is left, so an accept there loads element 0.
            if (count_q == '0) begin
                max_d = bus.I;
                idx_d = '0;
            end else if (gt) begin
                max_d = bus.I;
                idx_d = count_q;
            end

            if (count_q == LAST) begin
                count_d = '0;
                state_d = HOLD;
                valid_d = 1'b1;
            end else begin
                count_d = count_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= ACCUM;
            count_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign bus.I_ready = i_ready;
    assign bus.O_max   = max_q;
    assign bus.O_idx   = idx_q;
    assign bus.O_valid = valid_q;
endmodule

// File: doc/window_max_ugt.md
# window_max_ugt

Streaming windowed-maximum stage that sits directly upstream of the 4-bit unsigned greater-than comparator. It accepts unsigned samples over a valid/ready handshake and presents each sample alongside the stored running maximum to that comparator. It emits the maximum value and its index once per fixed window of WINDOW accepted samples. Ties keep the earliest index because the update rule is strict greater-than.

## Interface
- WIDTH, default 4: sample width in bits, unsigned.
- WINDOW, default 8: accepted samples per window; legal range is 2 to 2^16.
- IDX_W, default clog2(WINDOW): index and counter width (derived, not overridden).

- CLK  in  1  rising-edge clock.
- ASYNCRESET  in  1  reset, asynchronous and active-high; all flops clear immediately when asserted.
- I  in  WIDTH  input sample.
- I_valid  in  1  I is valid this cycle.
- I_ready  out  1  stage accepts I this cycle (combinational from state and O_ready).
- O_max  out  WIDTH  window maximum (registered).
- O_idx  out  IDX_W  index within the window of the first occurrence of O_max (registered).
- O_valid  out  1  O_max/O_idx hold a completed window (registered).
- O_ready  in  1  downstream takes the result this cycle.

## Operation
- Two states:
  - ACCUM: collecting samples.
  - HOLD: result presented.
- Accept: I_valid && I_ready at a rising edge.
- I_ready:
  - 1 in ACCUM.
  - In HOLD, equals O_ready. This lets the first sample of the next window enter on the same edge the result is taken.
- On accept with count == 0: max <= I, idx <= 0.
- On accept with count > 0:
  - If ugt(I, max) (strict): max <= I, idx <= count.
  - Otherwise max and idx are unchanged.
- Every accept increments count.
- On an accept with count == WINDOW-1: count <= 0, state <= HOLD, O_valid <= 1.
- HOLD with O_ready = 1 and no accept: state <= ACCUM, O_valid <= 0.
- HOLD with O_ready = 1 and an accept:
  - The result is consumed.
  - The new sample is loaded as window element 0.
  - state <= ACCUM and O_valid <= 0. The exception is WINDOW-1 == 0, which is illegal.
- HOLD with O_ready = 0: O_max, O_idx and O_valid are frozen. I_ready = 0, and I_valid is ignored.
- In ACCUM, O_max and O_idx track the running values and are don't-care. Downstream samples them only when O_valid is high.
- Comparison is unsigned, full WIDTH; there is no sign extension.
- Counter wrap: count never exceeds WINDOW-1. It resets to 0 on window completion, not by modular overflow.

## Timing
- Reset values:
  - state = ACCUM, count = 0.
  - O_max = 0, O_idx = 0, O_valid = 0.
  - I_ready = 1 (ACCUM), but no accept is registered while ASYNCRESET is high.
- Latency: O_valid rises on the edge that accepts the WINDOW-th sample, so the result is visible the following cycle.
- Throughput: one sample per cycle, sustained with no bubbles between windows, when O_ready = 1 in HOLD.
- Gaps in I_valid: no state change and no count change.
- Reset mid-window: the partial window is discarded, and the next accept after deassertion is index 0.
- Reset during HOLD: the pending result is dropped and O_valid falls asynchronously.
- No combinational path exists from I or I_valid to any output. The only combinational output path is O_ready -> I_ready.

## Structure
- The shared package holds:
  - the state enum (ACCUM, HOLD);
  - the WIDTH default constant;
  - an IDX_W helper function (clog2).
- One sub-module: the WIDTH-bit unsigned greater-than comparator, instantiated with in0 = I and in1 = running max; its out drives the update enable.
- Everything else is flat: state flop, count, max/idx registers, output valid flop.

## Test plan
- WINDOW=8, samples 3,7,2,7,9,1,9,0 back-to-back, O_ready=1 -> one result, O_max=9, O_idx=4, O_valid for 1 cycle.
- All-zero window of 8 -> O_max=0, O_idx=0; maximum at last position (0,…,0,15) -> O_max=15, O_idx=7.
- Backpressure: after a window completes, hold O_ready=0 for 5 cycles with I_valid=1 -> I_ready=0 and O_* stable for all 5 cycles, no samples lost. On release, the result is taken and the sample present that cycle becomes index 0 of the next window.
- Continuous stream of 24 samples, O_ready=1 -> exactly 3 results spaced 8 cycles apart, I_ready never low.
- I_valid toggling every other cycle across a window -> the result appears only after 8 accepts, and indices count accepts, not cycles.
- Assert ASYNCRESET mid-cycle after 5 accepted samples (including 15) -> outputs return to 0 immediately. The next 8 samples of value 4 give O_max=4, O_idx=0.
